// File: rtl/pedal_top.sv
// pedal_top: audio pedal datapath. Samples arrive from the Pico over an SPI
// slave link, pass through a transparent effect stage, and are re-serialised
// to the DAC over an SPI master link with a config nibble in front.
//
// DAC driver states:
//   state    | meaning
//   ST_IDLE  | all DAC outputs low, waiting for a start request
//   ST_SHIFT | frame in flight, one bit every DAC_SCLK_DIV clocks (mode 0)
module pedal_top #(
   parameter int          DAC_SCLK_DIV = 4,
   parameter logic [3:0]  DAC_CFG      = 4'b0011
) (
   input  logic clk_25mhz,
   input  logic reset,
   input  logic com_sclk_in,
   input  logic com_mosi_in,
   input  logic com_active,
   output logic spi_audio_clk,
   output logic spi_mosi_out,
   output logic spi_active_out
);

   localparam int DIV_W = $clog2(DAC_SCLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DAC_SCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DAC_SCLK_DIV / 2);

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } dac_state_t;

   // ---------------------------------------------------------------
   // Input synchronisers and SCLK edge detect
   // ---------------------------------------------------------------
   logic [1:0] sclk_sync_q;
   logic [1:0] mosi_sync_q;
   logic [1:0] cs_sync_q;
   logic       sclk_prev_q;
   logic       sclk_rise;

   // Two-flop synchronisers for the Pico link plus the edge-detect history flop.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[0], com_sclk_in};
         mosi_sync_q <= {mosi_sync_q[0], com_mosi_in};
         cs_sync_q   <= {cs_sync_q[0], com_active};
         sclk_prev_q <= sclk_sync_q[1];
      end
   end

   assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;

   // ---------------------------------------------------------------
   // SPI receiver and passthrough audio register
   // ---------------------------------------------------------------
   // Only 15 bits are held: the 16th bit goes straight into output_audio
   // on the completing edge, so a 16th flop would never be read.
   logic [14:0] shift_q;
   logic [3:0]  bit_cnt_q;
   logic        data_is_ready;
   logic [15:0] output_audio;

   // Shift in bits while selected; publish each complete word with a one-cycle strobe.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         data_is_ready <= 1'b0;
         output_audio  <= 16'h0000;
      end else begin
         data_is_ready <= 1'b0;
         if (!cs_sync_q[1]) begin
            bit_cnt_q <= '0;
         end else if (sclk_rise) begin
            shift_q <= {shift_q[13:0], mosi_sync_q[1]};
            if (bit_cnt_q == 4'd15) begin
               output_audio  <= {shift_q, mosi_sync_q[1]};
               data_is_ready <= 1'b1;
               bit_cnt_q     <= '0;
            end else begin
               bit_cnt_q <= bit_cnt_q + 4'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // DAC driver
   // ---------------------------------------------------------------
   // frame_q holds the frame below its MSB (which goes straight to MOSI at
   // start). The audio low nibble rides along at the bottom and is never
   // shifted out, since only 16 bits are sent.
   dac_state_t            state_q;
   logic [18:0]           frame_q;
   logic [3:0]            dac_bit_q;
   logic [DIV_W-1:0]      div_cnt_q;
   logic                  pend_q;
   logic                  act_q;
   logic                  sclk_q;
   logic                  mosi_q;
   logic                  start_req;

   // A strobe arriving while idle starts the frame on the very next edge.
   assign start_req = pend_q | data_is_ready;

   // DAC frame sequencer with registered SPI outputs and a single-deep request flag.
   always_ff @(posedge clk_25mhz or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         dac_bit_q <= '0;
         div_cnt_q <= '0;
         pend_q    <= 1'b0;
         act_q     <= 1'b0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               act_q  <= 1'b0;
               sclk_q <= 1'b0;
               mosi_q <= 1'b0;
               if (start_req) begin
                  state_q   <= ST_SHIFT;
                  pend_q    <= 1'b0;
                  frame_q   <= {DAC_CFG[2:0], output_audio};
                  act_q     <= 1'b1;
                  mosi_q    <= DAC_CFG[3];
                  dac_bit_q <= 4'd15;
                  div_cnt_q <= DIV_LAST;
               end
            end
            ST_SHIFT: begin
               if (data_is_ready) begin
                  pend_q <= 1'b1;
               end
               if (div_cnt_q == '0) begin
                  sclk_q <= 1'b0;
                  if (dac_bit_q == 4'd0) begin
                     state_q <= ST_IDLE;
                     act_q   <= 1'b0;
                     mosi_q  <= 1'b0;
                  end else begin
                     dac_bit_q <= dac_bit_q - 4'd1;
                     mosi_q    <= frame_q[18];
                     frame_q   <= {frame_q[17:0], 1'b0};
                     div_cnt_q <= DIV_LAST;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q - DIV_W'(1);
                  if (div_cnt_q == DIV_HALF) begin
                     sclk_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi_active_out = act_q;
   assign spi_audio_clk  = sclk_q;
   assign spi_mosi_out   = mosi_q;

endmodule

// File: tb/tb_pedal_top.sv
// Bench for pedal_top: drives Pico SPI words, predicts received words and DAC
// frames into queues, and compares them as the design produces them.
`timescale 1ns/1ps
module tb_pedal_top;

   logic clk_25mhz = 1'b0;
   logic reset     = 1'b1;
   logic tx_sclk   = 1'b0;
   logic tx_mosi   = 1'b0;
   logic tx_cs     = 1'b0;
   logic use2      = 1'b0;

   logic spi_audio_clk, spi_mosi_out, spi_active_out;
   logic sclk2, mosi2, act2;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] exp_words[$];
   logic [15:0] exp_frames[$];
   logic [15:0] frames2_q[$];

   int frames_started = 0;
   int cur_cyc = 0;
   int drdy2_cnt = 0;

   always #20 clk_25mhz = ~clk_25mhz;

   pedal_top dut (
      .clk_25mhz      (clk_25mhz),
      .reset          (reset),
      .com_sclk_in    (use2 ? 1'b0 : tx_sclk),
      .com_mosi_in    (use2 ? 1'b0 : tx_mosi),
      .com_active     (use2 ? 1'b0 : tx_cs),
      .spi_audio_clk  (spi_audio_clk),
      .spi_mosi_out   (spi_mosi_out),
      .spi_active_out (spi_active_out)
   );

   // Slow DAC instance so several words can land inside one frame.
   pedal_top #(.DAC_SCLK_DIV(32), .DAC_CFG(4'b0011)) dut2 (
      .clk_25mhz      (clk_25mhz),
      .reset          (reset),
      .com_sclk_in    (use2 ? tx_sclk : 1'b0),
      .com_mosi_in    (use2 ? tx_mosi : 1'b0),
      .com_active     (use2 ? tx_cs : 1'b0),
      .spi_audio_clk  (sclk2),
      .spi_mosi_out   (mosi2),
      .spi_active_out (act2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [15:0] dac_frame(input logic [15:0] w);
      return {4'b0011, w[15:4]};
   endfunction

   task automatic send_bits(input logic [15:0] w, input int n, input int half_ns);
      for (int i = 15; i > 15 - n; i--) begin
         tx_mosi = w[i];
         #(half_ns);
         tx_sclk = 1'b1;
         #(half_ns);
         tx_sclk = 1'b0;
      end
   endtask

   // DAC frame monitor for the main instance
   logic act_prev = 1'b0, sclk_prev = 1'b0, aborted = 1'b0;
   logic [15:0] cap;
   int edges;
   initial begin
      forever begin
         @(negedge clk_25mhz);
         if (spi_active_out && !act_prev) begin
            cap = '0; edges = 0; cur_cyc = 0; aborted = 1'b0;
            frames_started++;
         end
         if (reset) aborted = 1'b1;
         if (spi_active_out) begin
            cur_cyc++;
            if (spi_audio_clk && !sclk_prev) begin
               cap = {cap[14:0], spi_mosi_out};
               edges++;
            end
         end
         if (!spi_active_out && act_prev && !aborted && !reset) begin
            chk("frame_expected", (exp_frames.size() != 0), 1);
            if (exp_frames.size() != 0) chk("dac_frame", cap, exp_frames.pop_front());
            chk("dac_sclk_edges", edges, 16);
            chk("dac_active_cycles", cur_cyc, 64);
         end
         act_prev  = spi_active_out;
         sclk_prev = spi_audio_clk;
      end
   end

   // data_is_ready / output_audio monitor for the main instance
   initial begin
      logic was_idle;
      forever begin
         @(negedge clk_25mhz);
         if (dut.data_is_ready) begin
            was_idle = !spi_active_out;
            @(negedge clk_25mhz);
            chk("drdy_width", dut.data_is_ready, 0);
            chk("drdy_expected", (exp_words.size() != 0), 1);
            if (exp_words.size() != 0) chk("output_audio", dut.output_audio, exp_words.pop_front());
            if (was_idle && !reset) chk("active_latency", spi_active_out, 1);
         end
      end
   end

   // Frame capture and strobe count for the slow instance
   initial begin
      logic a2p, s2p;
      logic [15:0] c2;
      a2p = 1'b0; s2p = 1'b0; c2 = '0;
      forever begin
         @(negedge clk_25mhz);
         if (dut2.data_is_ready) drdy2_cnt++;
         if (act2 && !a2p) c2 = '0;
         if (act2 && sclk2 && !s2p) c2 = {c2[14:0], mosi2};
         if (!act2 && a2p) frames2_q.push_back(c2);
         a2p = act2;
         s2p = sclk2;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int fs0;
      bit found;
      logic [15:0] wa, wb, wc;

      // Reset
      #100;
      reset = 1'b0;
      @(negedge clk_25mhz);
      chk("reset_active", spi_active_out, 0);
      chk("reset_sclk", spi_audio_clk, 0);
      chk("reset_mosi", spi_mosi_out, 0);
      chk("reset_audio", dut.output_audio, 16'h0000);
      chk("reset_drdy", dut.data_is_ready, 0);

      // Passthrough
      exp_words.push_back(16'hC0DE);
      exp_frames.push_back(dac_frame(16'hC0DE));
      tx_cs = 1'b1; #250;
      send_bits(16'hC0DE, 16, 250);
      #250 tx_cs = 1'b0;
      #4000;

      // Aborted word followed by a full one
      tx_cs = 1'b1; #250;
      send_bits(16'hA500, 8, 250);
      #250 tx_cs = 1'b0;
      #500;
      exp_words.push_back(16'h1234);
      exp_frames.push_back(dac_frame(16'h1234));
      tx_cs = 1'b1; #250;
      send_bits(16'h1234, 16, 250);
      #250 tx_cs = 1'b0;
      #4000;
      chk("audio_after_abort", dut.output_audio, 16'h1234);

      // Back-to-back words under one chip select
      exp_words.push_back(16'hFFFF);
      exp_frames.push_back(dac_frame(16'hFFFF));
      exp_words.push_back(16'h0000);
      exp_frames.push_back(dac_frame(16'h0000));
      tx_cs = 1'b1; #250;
      send_bits(16'hFFFF, 16, 250);
      send_bits(16'h0000, 16, 250);
      #250 tx_cs = 1'b0;
      #4000;

      // Reset during DAC bit 7
      exp_words.push_back(16'h5A5A);
      fs0 = frames_started;
      tx_cs = 1'b1; #250;
      send_bits(16'h5A5A, 16, 250);
      #250 tx_cs = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk_25mhz);
         if (frames_started > fs0 && spi_active_out && cur_cyc >= 34) found = 1'b1;
      end
      chk("midframe_reached", found, 1);
      chk("midframe_active", spi_active_out, 1);
      #5 reset = 1'b1;
      #1;
      chk("async_rst_active", spi_active_out, 0);
      chk("async_rst_sclk", spi_audio_clk, 0);
      chk("async_rst_mosi", spi_mosi_out, 0);
      #100 reset = 1'b0;
      @(negedge clk_25mhz);
      chk("post_rst_audio", dut.output_audio, 16'h0000);
      fs0 = frames_started;
      repeat (300) @(negedge clk_25mhz);
      chk("no_resume_frames", frames_started, fs0);
      chk("no_resume_active", spi_active_out, 0);

      // Pending-request collapse on the slow instance
      wa = 16'h1357; wb = 16'h2468; wc = 16'h9ABC;
      use2 = 1'b1;
      tx_cs = 1'b1; #250;
      send_bits(wa, 16, 160);
      send_bits(wb, 16, 160);
      send_bits(wc, 16, 160);
      #200 tx_cs = 1'b0;
      #40000;
      use2 = 1'b0;
      chk("collapse_strobes", drdy2_cnt, 3);
      chk("collapse_frame_count", frames2_q.size(), 2);
      if (frames2_q.size() >= 2) begin
         chk("collapse_first_frame", frames2_q[0], dac_frame(wa));
         chk("collapse_second_frame", frames2_q[1], dac_frame(wc));
      end

      chk("words_drained", exp_words.size(), 0);
      chk("frames_drained", exp_frames.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
